enc_binder_stream: RTL and testbench
====================================

Name: enc_binder_stream

Overview:
- Time-multiplexed, pipelined successor to the fixed per-feature binder packs in the sparse HDC encoder.
- Accepts level hypervectors for FEATS_PER_BEAT features per beat over a valid/ready stream and walks all NUM_FEATURES features of a sample over successive beats.
- Binds each lane by circular rotation, using shift amounts indexed from the shared SHIFTS table starting at SHIFT_BASE.
- Feeds the bundler stage with a lane mask and a last-beat flag.

Parameters:
- HV_DIM, 1024: hypervector width in bits.
- FEATS_PER_BEAT, 4: lanes (features) processed per beat.
- NUM_FEATURES, 10: features per sample; need not be a multiple of FEATS_PER_BEAT.
- SHIFT_BASE, 0: index of feature 0's entry in SHIFTS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- sample_clr  in  1  synchronous flush: beat counter to 0, pipeline emptied.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- level_hv  in  [HV_DIM-1:0] x FEATS_PER_BEAT  level HVs, lane i = feature beat*FEATS_PER_BEAT+i.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- shifted_hv  out  [HV_DIM-1:0] x FEATS_PER_BEAT  bound HVs.
- out_lane_mask  out  FEATS_PER_BEAT  1 = lane carries a real feature.
- out_beat  out  BEAT_W  beat index of this output.
- out_last  out  1  final beat of the sample.

Behaviour:
- Reset: rst_n sampled on rising clk. On reset, out_valid=0, shifted_hv=0, out_lane_mask=0, out_beat=0, out_last=0, beat counter=0, and all pipeline valids=0.
- BEATS = ceil(NUM_FEATURES/FEATS_PER_BEAT). BEAT_W = max(1, $clog2(BEATS)). SHIFT_W = $clog2(HV_DIM).
- Rotation, per lane: shifted[(j+s) mod HV_DIM] = level[j], i.e. rotate toward MSB by s = SHIFTS[SHIFT_BASE + beat*FEATS_PER_BEAT + lane] mod HV_DIM. s=0 passes the input through.
- Pipeline: two stages, so latency is 2 cycles from an accepted beat to out_valid with no stall.
  - S1 registers level_hv, the shift amounts, the beat index and the mask.
  - S2 registers the rotated result.
- Flow control: global advance en = !out_valid || out_ready; in_ready = en. When en=0 every stage holds and outputs stay stable.
- Beat counter: increments on each accepted beat. Wraps to 0 after BEATS-1, and the wrapped beat is tagged last.
- Padding lanes: lanes with a feature index >= NUM_FEATURES have mask=0 and shifted_hv forced to 0.
- sample_clr: takes priority over acceptance in the same cycle. The coincident input beat is dropped, in_ready is irrelevant, and out_valid=0 on the next cycle.
- Mid-beat reset: behaves exactly like power-on reset; partial samples are discarded.
- SHIFT_BASE + NUM_FEATURES - 1 must lie inside SHIFTS. This is enforced by an elaboration-time $error.

Optional Feature:
- Macro ENC_BINDER_RT_SHIFT_EN.
- Defined: adds ports shift_we (in 1), shift_waddr (in $clog2(NUM_FEATURES)), shift_wdata (in SHIFT_W).
  - A local register table of NUM_FEATURES entries replaces the SHIFTS lookup.
  - Table is reset-initialised from SHIFTS[SHIFT_BASE+k].
  - A write takes effect for beats entering S1 on the cycle after the write.
- Undefined: no extra ports; shifts are elaboration-time constants and no table registers are inferred.

Decomposition:
- Package enc_pkg holds HV_DIM, FEATURES_PER_CC, the SHIFTS array, SHIFT_W, and a shift_t typedef.
- Sub-module enc_rot_unit: combinational HV_DIM-bit circular rotator with a runtime shift_t amount. One instance per lane, placed between S1 and S2.

Test Plan:
- HV_DIM=16, FEATS_PER_BEAT=4, NUM_FEATURES=10, SHIFTS[0..9]=0..9, lane input 16'h0001, out_ready=1, three back-to-back beats -> outputs at cycles 2,3,4:
  - beat0: 0001,0002,0004,0008.
  - beat2: lanes 0x0100,0x0200, then 0,0; mask=4'b0011, out_last=1 on beat2 only.
- Same config, out_ready held 0 for 5 cycles after first out_valid -> in_ready=0, shifted_hv/out_beat stable, no beat lost or duplicated after release.
- SHIFTS entry 17 with HV_DIM=16 and input 16'h8000 -> rotation by 1, output 16'h0001.
- sample_clr asserted together with the beat1 handshake -> beat1 dropped, out_valid=0 next cycle, next accepted beat tagged out_beat=0.
- rst_n low for one cycle while beat1 is in S2 -> all outputs 0 the following cycle, counter restarts at 0.
- With ENC_BINDER_RT_SHIFT_EN: write shift_waddr=0, shift_wdata=5, then send input 0x0001 on lane 0 -> lane 0 output 16'h0020; without the macro, same stimulus -> 16'h0001.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants for the sparse HDC encoder binders: default geometry,
// the per-feature rotation table SHIFTS and the shift amount type.
package enc_pkg;

    localparam int unsigned HV_DIM          = 1024;
    localparam int unsigned FEATURES_PER_CC = 4;
    localparam int unsigned SHIFT_W         = $clog2(HV_DIM);

    typedef logic [SHIFT_W-1:0] shift_t;

    localparam int unsigned SHIFTS_LEN = 32;

    // Entries are reduced modulo the binder's HV width at the rotator.
    localparam shift_t SHIFTS [SHIFTS_LEN] = '{
        10'd0,  10'd1,  10'd2,  10'd3,  10'd4,  10'd5,  10'd6,  10'd7,
        10'd8,  10'd9,  10'd10, 10'd11, 10'd12, 10'd13, 10'd14, 10'd15,
        10'd16, 10'd17, 10'd18, 10'd19, 10'd20, 10'd21, 10'd22, 10'd23,
        10'd24, 10'd25, 10'd26, 10'd27, 10'd28, 10'd29, 10'd30, 10'd31
    };

endpackage

// File: rtl/enc_rot_unit.sv
// Combinational circular rotator: dout[(j+s) mod HV_DIM] = din[j], s = amt mod HV_DIM.
module enc_rot_unit
    import enc_pkg::*;
#(
    parameter int unsigned HV_DIM = enc_pkg::HV_DIM
) (
    input  logic [HV_DIM-1:0] din,
    input  shift_t            amt,
    output logic [HV_DIM-1:0] dout
);

    logic [31:0]         amt_m;
    logic [2*HV_DIM-1:0] dbl;

    // The upper half of the doubled word shifted left is the left rotation.
    always_comb begin
        amt_m = 32'(amt) % HV_DIM;
        dbl   = {din, din} << amt_m;
        dout  = dbl[2*HV_DIM-1:HV_DIM];
    end

endmodule

// File: rtl/enc_binder_stream.sv
// Streamed binder: rotates FEATS_PER_BEAT level HVs per beat by their SHIFTS entries.
// Define ENC_BINDER_RT_SHIFT_EN for a runtime-writable shift table.
module enc_binder_stream
    import enc_pkg::*;
#(
    parameter int unsigned HV_DIM         = enc_pkg::HV_DIM,
    parameter int unsigned FEATS_PER_BEAT = enc_pkg::FEATURES_PER_CC,
    parameter int unsigned NUM_FEATURES   = 10,
    parameter int unsigned SHIFT_BASE     = 0,
    localparam int unsigned BEATS  = (NUM_FEATURES + FEATS_PER_BEAT - 1) / FEATS_PER_BEAT,
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     sample_clr,
`ifdef ENC_BINDER_RT_SHIFT_EN
    input  logic                                     shift_we,
    input  logic [((NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1)-1:0] shift_waddr,
    input  shift_t                                   shift_wdata,
`endif
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [FEATS_PER_BEAT-1:0][HV_DIM-1:0]    level_hv,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [FEATS_PER_BEAT-1:0][HV_DIM-1:0]    shifted_hv,
    output logic [FEATS_PER_BEAT-1:0]                out_lane_mask,
    output logic [BEAT_W-1:0]                        out_beat,
    output logic                                     out_last
);

    logic                                  en;
    logic                                  accept;
    logic                                  beat_last;
    logic [BEAT_W-1:0]                     beat_cnt;
    shift_t [FEATS_PER_BEAT-1:0]           lane_shift;
    logic [FEATS_PER_BEAT-1:0]             lane_mask;

    logic                                  s1_valid;
    logic [FEATS_PER_BEAT-1:0][HV_DIM-1:0] s1_hv;
    shift_t [FEATS_PER_BEAT-1:0]           s1_shift;
    logic [FEATS_PER_BEAT-1:0]             s1_mask;
    logic [BEAT_W-1:0]                     s1_beat;
    logic                                  s1_last;
    logic [FEATS_PER_BEAT-1:0][HV_DIM-1:0] bound_hv;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign accept    = in_valid && en && !sample_clr;
    assign beat_last = (beat_cnt == BEAT_W'(BEATS - 1));

    if (SHIFT_BASE + NUM_FEATURES > SHIFTS_LEN) begin : g_range_err
        $error("enc_binder_stream: SHIFT_BASE + NUM_FEATURES - 1 lies outside SHIFTS");
    end

`ifdef ENC_BINDER_RT_SHIFT_EN
    localparam int unsigned WADDR_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

    shift_t rt_tab [NUM_FEATURES];

    for (genvar k = 0; k < NUM_FEATURES; k++) begin : g_tab
        shift_t ent;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ent <= SHIFTS[SHIFT_BASE + k];
            end else if (shift_we && shift_waddr == WADDR_W'(k)) begin
                ent <= shift_wdata;
            end
        end
        assign rt_tab[k] = ent;
    end
`endif

    for (genvar l = 0; l < FEATS_PER_BEAT; l++) begin : g_lane
        logic [31:0]       feat;
        logic [HV_DIM-1:0] rot;

        assign feat         = 32'(beat_cnt) * FEATS_PER_BEAT + 32'(l);
        assign lane_mask[l] = (feat < NUM_FEATURES);

`ifdef ENC_BINDER_RT_SHIFT_EN
        assign lane_shift[l] = lane_mask[l] ? rt_tab[WADDR_W'(feat)] : '0;
`else
        // Constant column of this lane's shifts across beats, selected by the beat counter.
        shift_t col [BEATS];
        for (genvar b = 0; b < BEATS; b++) begin : g_beat
            if (b * FEATS_PER_BEAT + l < NUM_FEATURES) begin : g_real
                assign col[b] = SHIFTS[SHIFT_BASE + b * FEATS_PER_BEAT + l];
            end else begin : g_pad
                assign col[b] = '0;
            end
        end
        assign lane_shift[l] = col[beat_cnt];
`endif

        enc_rot_unit #(
            .HV_DIM(HV_DIM)
        ) u_rot (
            .din  (s1_hv[l]),
            .amt  (s1_shift[l]),
            .dout (rot)
        );

        assign bound_hv[l] = s1_mask[l] ? rot : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || sample_clr) begin
            beat_cnt  <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_hv    <= level_hv;
            s1_shift <= lane_shift;
            s1_mask  <= lane_mask;
            s1_beat  <= beat_cnt;
            s1_last  <= beat_last;
        end
    end

    // S2 only loads real beats, so outputs hold the last beat across bubbles and stalls.
    always_ff @(posedge clk) begin
        if (!rst_n || sample_clr) begin
            shifted_hv    <= '0;
            out_lane_mask <= '0;
            out_beat      <= '0;
            out_last      <= 1'b0;
        end else if (en && s1_valid) begin
            shifted_hv    <= bound_hv;
            out_lane_mask <= s1_mask;
            out_beat      <= s1_beat;
            out_last      <= s1_last;
        end
    end

endmodule

// File: tb/tb_enc_binder_stream.sv
// Scoreboard bench for enc_binder_stream (HV_DIM=16, 4 lanes, 10 features).
module tb_enc_binder_stream;
    import enc_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned FB = 4;
    localparam int unsigned NF = 10;
    localparam int unsigned NB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, sample_clr, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [FB-1:0][W-1:0] level_hv, shifted_hv;
    logic [FB-1:0]        out_lane_mask;
    logic [1:0]           out_beat;
`ifdef ENC_BINDER_RT_SHIFT_EN
    logic                 shift_we;
    logic [3:0]           shift_waddr;
    shift_t               shift_wdata;
    localparam logic [W-1:0] RT_EXP = 16'h0020;
`else
    localparam logic [W-1:0] RT_EXP = 16'h0001;
`endif

    logic                 b_in_valid, b_in_ready, b_out_valid, b_out_last;
    logic [FB-1:0][W-1:0] b_level, b_shifted;
    logic [FB-1:0]        b_mask;
    logic [1:0]           b_beat;

    enc_binder_stream #(
        .HV_DIM(W), .FEATS_PER_BEAT(FB), .NUM_FEATURES(NF), .SHIFT_BASE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_clr(sample_clr),
`ifdef ENC_BINDER_RT_SHIFT_EN
        .shift_we(shift_we), .shift_waddr(shift_waddr), .shift_wdata(shift_wdata),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .level_hv(level_hv),
        .out_valid(out_valid), .out_ready(out_ready), .shifted_hv(shifted_hv),
        .out_lane_mask(out_lane_mask), .out_beat(out_beat), .out_last(out_last)
    );

    enc_binder_stream #(
        .HV_DIM(W), .FEATS_PER_BEAT(FB), .NUM_FEATURES(NF), .SHIFT_BASE(17)
    ) dut_b17 (
        .clk(clk), .rst_n(rst_n), .sample_clr(1'b0),
`ifdef ENC_BINDER_RT_SHIFT_EN
        .shift_we(1'b0), .shift_waddr(4'd0), .shift_wdata('0),
`endif
        .in_valid(b_in_valid), .in_ready(b_in_ready), .level_hv(b_level),
        .out_valid(b_out_valid), .out_ready(1'b1), .shifted_hv(b_shifted),
        .out_lane_mask(b_mask), .out_beat(b_beat), .out_last(b_out_last)
    );

    typedef struct {
        logic [FB*W-1:0] hv;
        logic [FB-1:0]   mask;
        logic [1:0]      beat;
        logic            last;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    exp_t        e0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned mbeat  = 0;
    int unsigned mshift [NF];
    logic        rnd = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int unsigned s);
        logic [W-1:0] r = v;
        for (int unsigned i = 0; i < s % W; i++) r = {r[W-2:0], r[W-1]};
        return r;
    endfunction

    function automatic exp_t model(input logic [FB*W-1:0] hv, input int unsigned b);
        exp_t e;
        e.hv   = '0;
        e.mask = '0;
        e.beat = 2'(b);
        e.last = (b == NB - 1);
        for (int unsigned l = 0; l < FB; l++) begin
            int unsigned f = b * FB + l;
            if (f < NF) begin
                e.mask[l]      = 1'b1;
                e.hv[l*W +: W] = rotl(hv[l*W +: W], mshift[f]);
            end
        end
        return e;
    endfunction

    function automatic logic [FB*W-1:0] pat(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Output side pops first, then the input side pushes or flushes.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("sb_spurious", 64'(out_valid), 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("sb_hv",   shifted_hv,    mon_e.hv);
                check("sb_mask", out_lane_mask, mon_e.mask);
                check("sb_beat", out_beat,      mon_e.beat);
                check("sb_last", out_last,      mon_e.last);
            end
        end
        if (!rst_n || sample_clr) begin
            q.delete();
            mbeat = 0;
        end else if (in_valid && in_ready) begin
            q.push_back(model(level_hv, mbeat));
            mbeat = (mbeat == NB - 1) ? 0 : mbeat + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [FB*W-1:0] hv);
        int unsigned n = 0;
        level_hv = hv;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid),  64'd0);
        check({tag, "_hv"},    shifted_hv,      64'd0);
        check({tag, "_mask"},  out_lane_mask,   64'd0);
        check({tag, "_beat"},  out_beat,        64'd0);
        check({tag, "_last"},  64'(out_last),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [FB*W-1:0] p0, p1, p2;
        int unsigned n;
        rst_n = 1'b0; sample_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; level_hv = '0;
        b_in_valid = 1'b0; b_level = '0;
`ifdef ENC_BINDER_RT_SHIFT_EN
        shift_we = 1'b0; shift_waddr = '0; shift_wdata = '0;
`endif
        for (int unsigned k = 0; k < NF; k++) mshift[k] = k;
        repeat (2) tick();
        check_zero("rst");
        rst_n = 1'b1;
        tick();

        // back-to-back beats of one sample, latency 2
        send(pat(16'h0001, 16'h0001, 16'h0001, 16'h0001));
        check("lat1_valid", 64'(out_valid), 64'd0);
        send(pat(16'h0001, 16'h0001, 16'h0001, 16'h0001));
        check("lat2_valid", 64'(out_valid), 64'd1);
        check("lat2_hv", shifted_hv, 64'h0008_0004_0002_0001);
        send(pat(16'h0001, 16'h0001, 16'h0001, 16'h0001));
        drain();

        // downstream stall
        p0 = pat(16'h8001, 16'h00F0, 16'h1234, 16'hA5A5);
        p1 = pat(16'h0F0F, 16'hC003, 16'h0001, 16'hFFFE);
        p2 = pat(16'h7777, 16'h4000, 16'hDEAD, 16'hBEEF);
        e0 = model(p0, 0);
        out_ready = 1'b0;
        send(p0);
        send(p1);
        level_hv = p2;
        in_valid = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            check("stall_ready", 64'(in_ready),  64'd0);
            check("stall_hv",    shifted_hv,     e0.hv);
            check("stall_beat",  out_beat,       64'd0);
            tick();
        end
        out_ready = 1'b1;
        send(p2);
        drain();

        // sample_clr coincident with the beat1 handshake
        send(p0);
        level_hv = p1; in_valid = 1'b1; sample_clr = 1'b1;
        tick();
        sample_clr = 1'b0; in_valid = 1'b0;
        check("clr_valid1", 64'(out_valid), 64'd0);
        tick();
        check("clr_valid2", 64'(out_valid), 64'd0);
        send(p2);
        tick();
        check("clr_next_valid", 64'(out_valid), 64'd1);
        check("clr_next_beat",  out_beat,       64'd0);
        drain();

        // reset while beat1 sits in S2
        sample_clr = 1'b1; tick(); sample_clr = 1'b0;
        send(p1);
        send(p2);
        tick();
        check("pre_rst_beat", out_beat, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero("midrst");
        send(p0);
        tick();
        check("midrst_next_valid", 64'(out_valid), 64'd1);
        check("midrst_next_beat",  out_beat,       64'd0);
        drain();

        // SHIFT_BASE=17 instance: entry 17 rotates a 16-bit HV by 1
        check("b17_ready", 64'(b_in_ready), 64'd1);
        b_level = pat(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 10) begin
            tick();
            n++;
        end
        check("b17_valid", 64'(b_out_valid), 64'd1);
        for (int unsigned l = 0; l < FB; l++)
            check("b17_lane", b_shifted[l], rotl(16'h8000, 17 + l));
        check("b17_lane0", b_shifted[0], 64'h0001);

        // random patterns with random backpressure over two samples
        sample_clr = 1'b1; tick(); sample_clr = 1'b0;
        rnd = 1'b1;
        for (int unsigned i = 0; i < 2 * NB; i++) send({$urandom, $urandom});
        rnd = 1'b0;
        out_ready = 1'b1;
        drain();

        // runtime shift table write (falls back to the constant table by default)
        sample_clr = 1'b1; tick(); sample_clr = 1'b0;
`ifdef ENC_BINDER_RT_SHIFT_EN
        shift_we = 1'b1; shift_waddr = 4'd0; shift_wdata = 10'd5;
        tick();
        shift_we = 1'b0;
        mshift[0] = 5;
`endif
        send(pat(16'h0001, 16'h0000, 16'h0000, 16'h0000));
        tick();
        check("rt_lane0", shifted_hv[0], RT_EXP);
        drain();

        check("sb_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
